pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Central stall/issue sequencer for the 5-stage scalar/vector pipeline (IF, ID, EX, MEM, WB).
- Owns three things:
  - a register scoreboard that blocks RAW and WAW hazards at decode;
  - tracking of multi-cycle vector EXE ops and multi-cycle MEM ops as they move down the pipe;
  - per-pipe-register enable/bubble controls.
- Sits beside Control_Unit. Drives enable_i of Pipe_IF_ID, Pipe_ID_EX and Pipe_EX_MEM, plus the NOP-insert controls.

Parameters:
- R, 32, number of architectural registers tracked by the scoreboard.
- AW, 5, register address width; AW must equal clog2(R).
- CW, 32, width of the stall-cycle performance counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- Valid_ID_i  in  1  ID stage holds a real instruction.
- A1_ID_i  in  AW  source register 1 address.
- A2_ID_i  in  AW  source register 2 address.
- A3_ID_i  in  AW  destination register address.
- Reads1_ID_i  in  1  instruction reads A1.
- Reads2_ID_i  in  1  instruction reads A2.
- RegFile_WE_ID_i  in  1  instruction writes A3.
- ExeMulti_ID_i  in  1  instruction needs a multi-cycle vector EXE.
- MemOp_ID_i  in  1  instruction performs a multi-cycle memory access.
- Exe_Finished_i  in  1  EX stage multi-cycle op completes this cycle.
- Mem_Finished_i  in  1  MEM stage access completes this cycle.
- RFWE_WB_i  in  1  WB writes the register file this cycle.
- A3_WB_i  in  AW  WB destination address.
- Enable_IF_ID_o  out  1  Pipe_IF_ID advances.
- Enable_ID_EX_o  out  1  Pipe_ID_EX advances.
- Enable_EX_MEM_o  out  1  Pipe_EX_MEM advances.
- Bubble_EX_o  out  1  load NOP into ID/EX.
- Bubble_MEM_o  out  1  load NOP into EX/MEM.
- Bubble_WB_o  out  1  load NOP into MEM/WB.
- Issue_o  out  1  ID instruction is accepted into EX this cycle.
- State_o  out  2  registered stall cause: 0 RUN, 1 HAZARD, 2 WAIT_EXE, 3 WAIT_MEM.
- Stall_Count_o  out  CW  number of cycles with any stall.

Behaviour:
- Reset is asynchronous, active-high; one clock domain. While RST is high:
  - pend (R bits), exm_ex_q, mem_ex_q, mem_mem_q = 0;
  - State_o = 0; Stall_Count_o = 0;
  - all Enable_*, Bubble_* and Issue_o = 0.
- Combinational stall conditions, all computed from registered state:
  - mem_stall = mem_mem_q & ~Mem_Finished_i
  - exe_stall = exm_ex_q & ~Exe_Finished_i
  - hazard = Valid_ID_i & ((Reads1_ID_i & pend[A1]) | (Reads2_ID_i & pend[A2]) | (RegFile_WE_ID_i & pend[A3]))
- Priority of stall causes, highest first; outputs are combinational in the same cycle:
  - mem_stall: all three Enable = 0; Bubble_WB_o = 1.
  - else exe_stall: Enable_IF_ID = Enable_ID_EX = 0; Enable_EX_MEM = 1; Bubble_MEM_o = 1.
  - else hazard: Enable_IF_ID = 0; Enable_ID_EX = Enable_EX_MEM = 1; Bubble_EX_o = 1.
  - else: all Enable = 1; no bubbles.
  - Issue_o = Valid_ID_i in this last (no-stall) case only.
- Registered State_o: next-cycle value is the cause selected this cycle (3/2/1/0).
- Stall_Count_o increments when the cause is nonzero. It saturates at all-ones.
- Scoreboard:
  - Set pend[A3_ID_i] on a rising CLK when Issue_o & RegFile_WE_ID_i.
  - Clear pend[A3_WB_i] when RFWE_WB_i.
  - Same address set and clear in one cycle: set wins.
  - The hazard check ignores a same-cycle WB clear. Release is seen the following cycle, so the register-file write-then-read ordering needs no bypass.
  - Register 0 is tracked like any other register.
- Tracking registers, updated on each rising CLK:
  - exm_ex_q: if Enable_ID_EX, load Issue_o & ExeMulti_ID_i; else hold.
  - mem_ex_q: if Enable_ID_EX, load Issue_o & MemOp_ID_i; else hold.
  - mem_mem_q: if Enable_EX_MEM, load mem_ex_q & ~Bubble_MEM_o; else if Mem_Finished_i, clear to 0; else hold.
  - When exe_stall ends (Exe_Finished_i=1), EX advances normally that cycle.
- Exe_Finished_i or Mem_Finished_i asserted with no tracked op: ignored.
- Reset asserted mid-stall: all tracking and the scoreboard clear immediately. No pending release is remembered.
- Latency: hazard release is one cycle after the WB write. The issue decision takes zero cycles (combinational).

Test Plan:
- Reset mid-operation:
  - Stimulus: set pend[7], hold mem_stall, assert RST for 3 ns between edges.
  - Required: outputs 0 immediately; after release State_o=0, Stall_Count_o=0, a read of R7 issues at once.
- RAW hazard:
  - Stimulus: issue a write to R5, then next cycle an ID instruction with Reads1, A1=5; RFWE_WB_i with A3_WB_i=5 three cycles later.
  - Required: Bubble_EX_o=1 and Enable_IF_ID_o=0 until the cycle after WB; Issue_o=1 on that cycle; Stall_Count_o=4.
- Set/clear collision:
  - Stimulus: WB clears R9 on the same edge an issue sets R9.
  - Required: pend[9]=1; a subsequent read of R9 stalls.
- Multi-cycle EXE:
  - Stimulus: issue with ExeMulti_ID_i=1; Exe_Finished_i held low 5 cycles, then pulsed.
  - Required: State_o=2 for 5 cycles; Bubble_MEM_o=1; IF/ID and ID/EX frozen; resumes on the pulse cycle.
- MEM over EXE priority:
  - Stimulus: MemOp in MEM (Mem_Finished_i low) while an ExeMulti op is in EX.
  - Required: all enables 0, Bubble_WB_o=1, State_o=3; after Mem_Finished_i, State_o=2 until Exe_Finished_i.
- No-op finish pulses:
  - Stimulus: Exe_Finished_i=1 and Mem_Finished_i=1 with nothing tracked.
  - Required: no state change; Issue_o follows Valid_ID_i.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/issue sequencer with register scoreboard
// Tracks pending writes and multi-cycle EX/MEM ops; drives pipe-register enables and bubbles.
module pipeline_hazard_controller #(
  parameter int R  = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          Valid_ID_i,
  input  logic [AW-1:0] A1_ID_i,
  input  logic [AW-1:0] A2_ID_i,
  input  logic [AW-1:0] A3_ID_i,
  input  logic          Reads1_ID_i,
  input  logic          Reads2_ID_i,
  input  logic          RegFile_WE_ID_i,
  input  logic          ExeMulti_ID_i,
  input  logic          MemOp_ID_i,
  input  logic          Exe_Finished_i,
  input  logic          Mem_Finished_i,
  input  logic          RFWE_WB_i,
  input  logic [AW-1:0] A3_WB_i,
  output logic          Enable_IF_ID_o,
  output logic          Enable_ID_EX_o,
  output logic          Enable_EX_MEM_o,
  output logic          Bubble_EX_o,
  output logic          Bubble_MEM_o,
  output logic          Bubble_WB_o,
  output logic          Issue_o,
  output logic [1:0]    State_o,
  output logic [CW-1:0] Stall_Count_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HAZARD   = 2'd1,
    ST_WAIT_EXE = 2'd2,
    ST_WAIT_MEM = 2'd3
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [R-1:0]  pend_q, pend_d;
  logic          exm_ex_q, exm_ex_d;
  logic          mem_ex_q, mem_ex_d;
  logic          mem_mem_q, mem_mem_d;
  state_e        state_q, state_d;
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;

  logic   mem_stall, exe_stall, hazard;
  state_e cause;
  logic   en_if_id, en_id_ex, en_ex_mem;
  logic   bub_ex, bub_mem, bub_wb;
  logic   issue;

  // Hazard check uses only registered pend; a same-cycle WB release is seen next cycle.
  always_comb begin
    mem_stall = mem_mem_q & ~Mem_Finished_i;
    exe_stall = exm_ex_q & ~Exe_Finished_i;
    hazard    = Valid_ID_i & ((Reads1_ID_i & pend_q[A1_ID_i]) |
                              (Reads2_ID_i & pend_q[A2_ID_i]) |
                              (RegFile_WE_ID_i & pend_q[A3_ID_i]));
  end

  always_comb begin
    cause     = ST_RUN;
    en_if_id  = 1'b1;
    en_id_ex  = 1'b1;
    en_ex_mem = 1'b1;
    bub_ex    = 1'b0;
    bub_mem   = 1'b0;
    bub_wb    = 1'b0;
    issue     = 1'b0;
    if (mem_stall) begin
      cause     = ST_WAIT_MEM;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      bub_wb    = 1'b1;
    end else if (exe_stall) begin
      cause     = ST_WAIT_EXE;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      bub_mem   = 1'b1;
    end else if (hazard) begin
      cause     = ST_HAZARD;
      en_if_id  = 1'b0;
      bub_ex    = 1'b1;
    end else begin
      issue     = Valid_ID_i;
    end
  end

  // Control outputs are forced quiet for the whole time reset is held.
  always_comb begin
    Enable_IF_ID_o  = en_if_id & ~RST;
    Enable_ID_EX_o  = en_id_ex & ~RST;
    Enable_EX_MEM_o = en_ex_mem & ~RST;
    Bubble_EX_o     = bub_ex & ~RST;
    Bubble_MEM_o    = bub_mem & ~RST;
    Bubble_WB_o     = bub_wb & ~RST;
    Issue_o         = issue & ~RST;
    State_o         = state_q;
    Stall_Count_o   = stall_cnt_q;
  end

  // Scoreboard: clear applied first so a same-address set on the same edge wins.
  always_comb begin
    pend_d = pend_q;
    if (RFWE_WB_i) begin
      pend_d[A3_WB_i] = 1'b0;
    end
    if (issue && RegFile_WE_ID_i) begin
      pend_d[A3_ID_i] = 1'b1;
    end
  end

  always_comb begin
    exm_ex_d  = exm_ex_q;
    mem_ex_d  = mem_ex_q;
    mem_mem_d = mem_mem_q;
    if (en_id_ex) begin
      exm_ex_d = issue & ExeMulti_ID_i;
      mem_ex_d = issue & MemOp_ID_i;
    end
    if (en_ex_mem) begin
      mem_mem_d = mem_ex_q & ~bub_mem;
    end else if (Mem_Finished_i) begin
      mem_mem_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = cause;
    stall_cnt_d = stall_cnt_q;
    if ((cause != ST_RUN) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend_q      <= '0;
      exm_ex_q    <= 1'b0;
      mem_ex_q    <= 1'b0;
      mem_mem_q   <= 1'b0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      exm_ex_q    <= exm_ex_d;
      mem_ex_q    <= mem_ex_d;
      mem_mem_q   <= mem_mem_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed table, reset sequence and randomized model checks
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic        valid, r1, r2, we, exm, mop, ef, mf, wbwe;
  logic [4:0]  a1, a2, a3, a3wb;
  logic        en_if, en_id, en_ex, b_ex, b_mem, b_wb, issue_o;
  logic [1:0]  state_o;
  logic [31:0] cnt_o;
  logic [5:0]  ctl_act;

  assign ctl_act = {en_if, en_id, en_ex, b_ex, b_mem, b_wb};

  pipeline_hazard_controller #(.R(32), .AW(5), .CW(32)) dut (
    .CLK(CLK), .RST(RST),
    .Valid_ID_i(valid), .A1_ID_i(a1), .A2_ID_i(a2), .A3_ID_i(a3),
    .Reads1_ID_i(r1), .Reads2_ID_i(r2), .RegFile_WE_ID_i(we),
    .ExeMulti_ID_i(exm), .MemOp_ID_i(mop),
    .Exe_Finished_i(ef), .Mem_Finished_i(mf),
    .RFWE_WB_i(wbwe), .A3_WB_i(a3wb),
    .Enable_IF_ID_o(en_if), .Enable_ID_EX_o(en_id), .Enable_EX_MEM_o(en_ex),
    .Bubble_EX_o(b_ex), .Bubble_MEM_o(b_mem), .Bubble_WB_o(b_wb),
    .Issue_o(issue_o), .State_o(state_o), .Stall_Count_o(cnt_o)
  );

  always #5 CLK = ~CLK;

  localparam logic [5:0] C_RUN = 6'b111000;
  localparam logic [5:0] C_HAZ = 6'b011100;
  localparam logic [5:0] C_EXE = 6'b001010;
  localparam logic [5:0] C_MEM = 6'b000001;
  localparam logic [5:0] C_OFF = 6'b000000;

  typedef struct {
    logic       valid, r1, r2, we, exm, mop, ef, mf, wbwe;
    logic [4:0] a1, a2, a3, a3wb;
    logic [5:0] ctl;
    logic       issue;
    logic [1:0] st;
    logic [31:0] cnt;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic v, input int ia1, input int ia2, input int ia3,
                              input logic ir1, input logic ir2, input logic iwe,
                              input logic iexm, input logic imop, input logic ief, input logic imf,
                              input logic iwb, input int iwba,
                              input logic [5:0] ctl, input logic is, input int st, input int cnt);
    vec_t t;
    t.valid = v; t.a1 = 5'(ia1); t.a2 = 5'(ia2); t.a3 = 5'(ia3);
    t.r1 = ir1; t.r2 = ir2; t.we = iwe; t.exm = iexm; t.mop = imop;
    t.ef = ief; t.mf = imf; t.wbwe = iwb; t.a3wb = 5'(iwba);
    t.ctl = ctl; t.issue = is; t.st = 2'(st); t.cnt = 32'(cnt);
    return t;
  endfunction

  task automatic clear_inputs();
    valid = 0; r1 = 0; r2 = 0; we = 0; exm = 0; mop = 0; ef = 0; mf = 0; wbwe = 0;
    a1 = 0; a2 = 0; a3 = 0; a3wb = 0;
  endtask

  // Reference model: pipeline contents as plain flags, pending writes as a bit array.
  bit          m_pend[32];
  bit          m_ex_multi, m_ex_mem, m_mem_busy;
  int          m_state;
  logic [31:0] m_cnt;

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_ex_multi = 0; m_ex_mem = 0; m_mem_busy = 0; m_state = 0; m_cnt = 0;
  endtask

  function automatic int model_cause();
    if (m_mem_busy && !mf) return 3;
    if (m_ex_multi && !ef) return 2;
    if (valid && ((r1 && m_pend[a1]) || (r2 && m_pend[a2]) || (we && m_pend[a3]))) return 1;
    return 0;
  endfunction

  function automatic logic [5:0] ctl_of(input int c);
    case (c)
      0: return C_RUN;
      1: return C_HAZ;
      2: return C_EXE;
      default: return C_MEM;
    endcase
  endfunction

  task automatic model_step(input int c);
    bit iss, leaving_mem;
    iss = valid && (c == 0);
    leaving_mem = m_ex_mem;
    // The instruction in ID moves to EX unless frozen; a hazard sends a bubble instead.
    if (c <= 1) begin
      m_ex_multi = iss && exm;
      m_ex_mem   = iss && mop;
    end
    // EX content reaches MEM unless EX is frozen on its own multi-cycle op.
    if (c <= 1) m_mem_busy = leaving_mem;
    else if (c == 2) m_mem_busy = 0;
    else if (mf) m_mem_busy = 0;
    if (wbwe) m_pend[a3wb] = 0;
    if (iss && we) m_pend[a3] = 1;
    m_state = c;
    if (c != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
    model_reset();
  endtask

  vec_t tbl[$];

  initial begin
    // valid a1 a2 a3 r1 r2 we exm mop ef mf wb wba | ctl issue state cnt
    tbl.push_back(mk(1,0,0,5, 0,0,1, 0,0,0,0, 0,0, C_RUN,1,0,0));
    tbl.push_back(mk(1,5,0,6, 1,0,0, 0,0,0,0, 0,0, C_HAZ,0,0,0));
    tbl.push_back(mk(1,5,0,6, 1,0,0, 0,0,0,0, 0,0, C_HAZ,0,1,1));
    tbl.push_back(mk(1,5,0,6, 1,0,0, 0,0,0,0, 0,0, C_HAZ,0,1,2));
    tbl.push_back(mk(1,5,0,6, 1,0,0, 0,0,0,0, 1,5, C_HAZ,0,1,3));
    tbl.push_back(mk(1,5,0,6, 1,0,0, 0,0,0,0, 0,0, C_RUN,1,1,4));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_RUN,0,0,4));
    tbl.push_back(mk(1,0,0,9, 0,0,1, 0,0,0,0, 1,9, C_RUN,1,0,4));
    tbl.push_back(mk(1,9,0,0, 1,0,0, 0,0,0,0, 0,0, C_HAZ,0,0,4));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 1,9, C_RUN,0,1,5));
    tbl.push_back(mk(1,9,0,0, 1,0,0, 0,0,0,0, 0,0, C_RUN,1,0,5));
    tbl.push_back(mk(1,0,0,0, 0,0,1, 0,0,0,0, 0,0, C_RUN,1,0,5));
    tbl.push_back(mk(1,0,0,3, 0,1,0, 0,0,0,0, 0,0, C_HAZ,0,0,5));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 1,0, C_RUN,0,1,6));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,0,0,0, 0,0, C_RUN,1,0,6));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,0,6));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,2,7));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,2,8));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,2,9));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,2,10));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1,0, 0,0, C_RUN,1,2,11));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_RUN,0,0,11));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,1,0,0, 0,0, C_RUN,1,0,11));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 1,0,0,0, 0,0, C_RUN,1,0,11));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_MEM,0,0,11));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_MEM,0,3,12));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,1, 0,0, C_EXE,0,3,13));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_EXE,0,2,14));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1,0, 0,0, C_RUN,1,2,15));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,1,1, 0,0, C_RUN,0,0,15));
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0,1,1, 0,0, C_RUN,1,0,15));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0,0, 0,0, C_RUN,0,0,15));

    clear_inputs();
    RST = 1;
    valid = 1;
    #12;
    check("reset_ctl", ctl_act, C_OFF);
    check("reset_issue", issue_o, 0);
    check("reset_state", state_o, 0);
    check("reset_cnt", cnt_o, 0);
    @(negedge CLK);
    do_reset();

    foreach (tbl[i]) begin
      valid = tbl[i].valid; a1 = tbl[i].a1; a2 = tbl[i].a2; a3 = tbl[i].a3;
      r1 = tbl[i].r1; r2 = tbl[i].r2; we = tbl[i].we; exm = tbl[i].exm; mop = tbl[i].mop;
      ef = tbl[i].ef; mf = tbl[i].mf; wbwe = tbl[i].wbwe; a3wb = tbl[i].a3wb;
      #1;
      check($sformatf("tbl%0d_ctl", i), ctl_act, tbl[i].ctl);
      check($sformatf("tbl%0d_issue", i), issue_o, tbl[i].issue);
      check($sformatf("tbl%0d_state", i), state_o, tbl[i].st);
      check($sformatf("tbl%0d_cnt", i), cnt_o, tbl[i].cnt);
      @(posedge CLK);
      @(negedge CLK);
    end

    // Reset mid-stall: pend[7] set and a MEM op waiting when reset hits between edges.
    do_reset();
    valid = 1; we = 1; a3 = 7; mop = 1;
    @(posedge CLK); @(negedge CLK);
    clear_inputs();
    @(posedge CLK); @(negedge CLK);
    #1 check("rstseq_memstall", ctl_act, C_MEM);
    @(posedge CLK); @(negedge CLK);
    valid = 1; r1 = 1; a1 = 7;
    #1 check("rstseq_state3", state_o, 3);
    RST = 1;
    #1;
    check("rstseq_ctl_off", ctl_act, C_OFF);
    check("rstseq_issue_off", issue_o, 0);
    check("rstseq_state_clr", state_o, 0);
    check("rstseq_cnt_clr", cnt_o, 0);
    #2 RST = 0;
    #0.5;
    check("rstseq_ctl_run", ctl_act, C_RUN);
    check("rstseq_r7_issue", issue_o, 1);
    @(posedge CLK); @(negedge CLK);
    #1;
    check("rstseq_state_after", state_o, 0);
    check("rstseq_cnt_after", cnt_o, 0);
    check("rstseq_issue_after", issue_o, 1);
    @(negedge CLK);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int c;
      valid = ($urandom_range(0, 99) < 75);
      a1 = 5'($urandom_range(0, 7)); a2 = 5'($urandom_range(0, 7)); a3 = 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 99) < 50); r2 = ($urandom_range(0, 99) < 50);
      we = ($urandom_range(0, 99) < 50);
      exm = ($urandom_range(0, 99) < 15); mop = ($urandom_range(0, 99) < 20);
      ef = ($urandom_range(0, 99) < 35); mf = ($urandom_range(0, 99) < 35);
      wbwe = ($urandom_range(0, 99) < 40); a3wb = 5'($urandom_range(0, 7));
      #1;
      c = model_cause();
      check("rand_ctl", ctl_act, ctl_of(c));
      check("rand_issue", issue_o, valid && (c == 0));
      check("rand_state", state_o, m_state);
      check("rand_cnt", cnt_o, m_cnt);
      model_step(c);
      @(posedge CLK);
      @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
